risc_datapath: RTL
==================

# risc_datapath

Execution datapath of the simple RISC core, directly downstream of the controller FSM. It holds the 8-entry register file, the A/B/C pipeline registers, the B-operand shifter, the ALU and the 3-bit status register. Every load, select and write strobe comes from the controller. Its C-register output feeds the RAM address/data path and the register write-back mux.

## Interface
Parameters:
- `WIDTH`, 16: datapath word width.
- `PCW`, 8: program-counter width, zero-extended on the PC write-back path.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- `write` in 1: register-file write enable.
- `writenum` in 3: write register index.
- `readnum` in 3: read register index (single read port).
- `vsel` in 2: write-back source select. 00 mdata, 01 sximm8, 10 {0,pc}, 11 C.
- `loada` in 1: load register A from the read port.
- `loadb` in 1: load register B from the read port.
- `asel` in 1: A-operand select. 1 forces the ALU A input to 0; 0 uses register A.
- `bsel` in 1: B-operand select. 1 uses sximm5; 0 uses shifted B.
- `loadc` in 1: load register C from the ALU result.
- `loads` in 1: load the status register from ALU flags.
- `shift` in 2: shift applied to B.
- `ALUop` in 2: ALU operation.
- `mdata` in WIDTH: RAM read data.
- `sximm8` in WIDTH: sign-extended 8-bit immediate from the decoder.
- `sximm5` in WIDTH: sign-extended 5-bit immediate from the decoder.
- `pc` in PCW: current program counter.
- `datapath_out` out WIDTH: register C.
- `status` out 3: {N, V, Z}.

## Operation
- Register file: 8 × WIDTH.
  - Read is combinational: `regs[readnum]`.
  - Write is synchronous: when `write`=1, `regs[writenum]` takes the write-back mux value on the rising edge.
- Shifter on B:
  - 00: pass through.
  - 01: shift left 1, LSB ← 0.
  - 10: logical shift right 1, MSB ← 0.
  - 11: arithmetic shift right 1, MSB kept.
- ALU, with Ain = asel ? 0 : A and Bin = bsel ? sximm5 : shifted B:
  - 00: Ain + Bin.
  - 01: Ain − Bin.
  - 10: Ain & Bin.
  - 11: ~Bin.
  - All results are truncated to WIDTH.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD and SUB; V = 0 for AND and MVN.
- A, B, C and status hold their value unless their load strobe is asserted.
- Simultaneous strobes are all legal and act independently on the same edge.
  - `loadc` with `write` and vsel=11: the register file receives the pre-edge C.
  - `loada` with `loadb`: both receive the same read-port value.
  - `write` to index k while `readnum`=k and `loada`/`loadb`: A/B capture the pre-write value. There is no bypass.
- X or undefined strobes are not tolerated. Verification asserts that the strobes are known whenever `reset`=0.

## Timing
- Reset, asynchronous and immediate: all 8 registers, A, B and C go to 0, and `status` goes to 3'b000. `datapath_out` = 0 while `reset` is high.
- Reset asserted mid-instruction discards all partial state. The first edge after deassertion behaves as from power-up.
- `datapath_out` changes only on the edge where `loadc`=1 (one-edge latency from the strobe). `status` follows the same rule with `loads`.
- Minimum register-to-register operation (Rm → B, Rn → A, ALU → C, C → Rd) is 4 edges. MOV-immediate is 1 edge.
- There are no combinational paths from inputs to outputs: `datapath_out` and `status` are registered.

## Structure
- Shared package `risc_pkg`:
  - vsel codes (MDATA, SXIMM8, ZEROANDPC, C).
  - ALUop codes (ADD, CMP, AND, MVN).
  - shift codes.
  - nsel codes (RN, RD, RM), which are used by the controller and the decoder.
- Sub-module `reg_file8`: 8 × WIDTH storage with async reset, one combinational read port and one synchronous write port.
- Shifter, ALU and the A/B/C/status registers are inline in `risc_datapath`.

## Test plan
- Reset: write R3 = 0x1234, then pulse `reset` asynchronously mid-cycle → `datapath_out`=0 and `status`=000 immediately; reading R3 returns 0.
- MOV immediate: vsel=01, sximm8=0xFFF6, write R2, then read R2 → 0xFFF6. Write R2 again with vsel=11 while C=0x0005 → R2=0x0005.
- ADD with shift: R0=7, R1=3, shift=01 (B=6), ALUop=00, loadc → `datapath_out`=0x000D. Follow with the C → R4 write-back (vsel=11, `write`) and check R4=0x000D.
- CMP flags:
  - R0=0x7FFF, R1=0xFFFF, ALUop=01, `loads` → status N=1, V=1, Z=0; `datapath_out` unchanged.
  - Then R0=R1=5 → Z=1, N=0, V=0.
- LDR/STR address path: A=0x0010, bsel=1, sximm5=0xFFFE, asel=0, ALUop=00 → C=0x000E. Repeat with asel=1 → C=0xFFFE.
- Simultaneous events:
  - `loadc` and `write`(vsel=11) on the same edge → the register gets the old C.
  - `write` R5=9 with `readnum`=5 and `loadb` on the same edge → B gets the old R5.
  - MVN with shift=11 on B=0x8000 → C=0x3FFF.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared encodings for the RISC core: write-back select, ALU op, shifter
// and register-select codes, plus the signed-overflow helper.
package risc_pkg;

    typedef enum logic [1:0] {
        VSEL_MDATA     = 2'b00,
        VSEL_SXIMM8    = 2'b01,
        VSEL_ZEROANDPC = 2'b10,
        VSEL_C         = 2'b11
    } vsel_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_CMP = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    // Register-select codes for the controller and decoder (one-hot).
    typedef enum logic [2:0] {
        NSEL_RN = 3'b100,
        NSEL_RD = 3'b010,
        NSEL_RM = 3'b001
    } nsel_e;

    // Signed overflow from the operand and result sign bits; only the
    // arithmetic ops can overflow.
    function automatic logic alu_ovf(input logic [1:0] op, input logic sa,
                                     input logic sb, input logic sr);
        logic v;
        v = 1'b0;
        if (op == ALU_ADD)      v = (sa == sb) && (sr != sa);
        else if (op == ALU_CMP) v = (sa != sb) && (sr != sa);
        return v;
    endfunction

endpackage

// File: rtl/risc_datapath_reg_file8.sv
// 8-entry register file: one combinational read port, one synchronous
// write port, every entry cleared by the asynchronous reset.
module reg_file8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [2:0]       writenum,
    input  logic [2:0]       readnum,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [7:0][WIDTH-1:0] regs_q, regs_d;

    // Next-state of the array: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (write) regs_d[writenum] = wdata;
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    assign rdata = regs_q[readnum];

endmodule

// File: rtl/risc_datapath.sv
// Execution datapath: register file, A/B/C pipeline registers, B shifter,
// ALU and the {N,V,Z} status register. All strobes come from the controller.
module risc_datapath
    import risc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PCW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [2:0]       writenum,
    input  logic [2:0]       readnum,
    input  logic [1:0]       vsel,
    input  logic             loada,
    input  logic             loadb,
    input  logic             asel,
    input  logic             bsel,
    input  logic             loadc,
    input  logic             loads,
    input  logic [1:0]       shift,
    input  logic [1:0]       ALUop,
    input  logic [WIDTH-1:0] mdata,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [PCW-1:0]   pc,
    output logic [WIDTH-1:0] datapath_out,
    output logic [2:0]       status
);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]       status_q, status_d;
    logic [WIDTH-1:0] rdata, wdata;
    logic [WIDTH-1:0] b_sh, a_in, b_in, alu_out;
    logic [2:0]       flags;

    // Write-back source mux; the C path sees the pre-edge value of C.
    always_comb begin
        wdata = c_q;
        case (vsel)
            VSEL_MDATA:     wdata = mdata;
            VSEL_SXIMM8:    wdata = sximm8;
            VSEL_ZEROANDPC: wdata = {{(WIDTH-PCW){1'b0}}, pc};
            default:        wdata = c_q;
        endcase
    end

    reg_file8 #(.WIDTH(WIDTH)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .readnum  (readnum),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    // Shifter, operand selection, ALU and flag generation.
    always_comb begin
        b_sh = b_q;
        case (shift)
            SH_LSL:  b_sh = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR:  b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_sh = b_q;
        endcase
        a_in = asel ? '0 : a_q;
        b_in = bsel ? sximm5 : b_sh;
        alu_out = '0;
        case (ALUop)
            ALU_ADD: alu_out = a_in + b_in;
            ALU_CMP: alu_out = a_in - b_in;
            ALU_AND: alu_out = a_in & b_in;
            default: alu_out = ~b_in;
        endcase
        flags = {alu_out[WIDTH-1],
                 alu_ovf(ALUop, a_in[WIDTH-1], b_in[WIDTH-1], alu_out[WIDTH-1]),
                 (alu_out == '0)};
    end

    // Pipeline register next-state: each holds unless its strobe is set.
    always_comb begin
        a_d      = loada ? rdata   : a_q;
        b_d      = loadb ? rdata   : b_q;
        c_d      = loadc ? alu_out : c_q;
        status_d = loads ? flags   : status_q;
    end

    // A/B/C/status registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 3'b000;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    assign datapath_out = c_q;
    assign status       = status_q;

endmodule
